// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and flag controller of the asynchronous FIFO (write clock domain).
// Keeps the binary and Gray write pointers and derives full, almost_full, level and overflow.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH      = 4,
    parameter int ALMOST_FULL_THR = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rq_rptr_gray,
    input  logic                  ovf_clr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int             PW     = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]  AF_THR = PW'(ALMOST_FULL_THR);

    logic [PW-1:0] wbin_q,  wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q,  full_d;
    logic          af_q,    af_d;
    logic          ovf_q,   ovf_d;
    logic [PW-1:0] rbin;
    logic [PW-1:0] full_cmp;
    logic          accept;

    // Handshake: a write is taken in the cycle where wr_en=1 and the registered
    // full is 0; wr_en while full is dropped and only recorded as overflow.
    // Nothing is accepted while rst is high, so the RAM never sees a reset-edge write.
    always_comb begin
        accept = wr_en & ~full_q & ~rst;
    end

    // Gray-to-binary: bit i is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(rq_rptr_gray >> i);
        end
    end

    always_comb begin
        wbin_d   = wbin_q + {{(PW-1){1'b0}}, accept};
        wgray_d  = (wbin_d >> 1) ^ wbin_d;
        full_cmp = {~rq_rptr_gray[PW-1:PW-2], rq_rptr_gray[PW-3:0]};
        full_d   = (wgray_d == full_cmp);
        level_d  = wbin_d - rbin;
        af_d     = (level_d >= AF_THR);
        // A set in the same cycle as a clear takes precedence.
        ovf_d    = (wr_en & full_q) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mem_we      = accept;
    assign wr_addr     = wbin_q[ADDR_WIDTH-1:0];
    assign wr_ptr_gray = wgray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wr_level    = level_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed cycles push expected outputs into a queue,
// a negedge monitor pops and compares them and checks single-bit Gray steps.
module tb_fifo_wr_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [4:0] rq_rptr_gray;
    logic       ovf_clr;
    logic       mem_we;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr_gray;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_level;
    logic       overflow;

    fifo_wr_ctrl #(.ADDR_WIDTH(4), .ALMOST_FULL_THR(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rq_rptr_gray (rq_rptr_gray),
        .ovf_clr      (ovf_clr),
        .mem_we       (mem_we),
        .wr_addr      (wr_addr),
        .wr_ptr_gray  (wr_ptr_gray),
        .full         (full),
        .almost_full  (almost_full),
        .wr_level     (wr_level),
        .overflow     (overflow)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       mem_we;
        logic [3:0] wr_addr;
        logic [4:0] gray;
        logic       full;
        logic       af;
        logic [4:0] lvl;
        logic       ovf;
        logic       after_rst;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: occupancy is tracked as an integer difference and full
    // is simply "16 entries outstanding", independent of the Gray compare.
    logic [4:0] m_wbin;
    logic       m_full;
    logic       m_af;
    logic [4:0] m_lvl;
    logic       m_ovf;
    logic       m_prev_rst;

    function automatic logic [4:0] gray5(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic w, input logic c, input int rb);
        exp_t       e;
        logic [4:0] rb5;
        logic       acc;
        rb5 = rb[4:0];
        @(posedge clk);
        #1;
        rst          = r;
        wr_en        = w;
        ovf_clr      = c;
        rq_rptr_gray = gray5(rb5);
        e.mem_we     = w & ~m_full & ~r;
        e.wr_addr    = m_wbin[3:0];
        e.gray       = gray5(m_wbin);
        e.full       = m_full;
        e.af         = m_af;
        e.lvl        = m_lvl;
        e.ovf        = m_ovf;
        e.after_rst  = m_prev_rst;
        exp_q.push_back(e);
        if (r) begin
            m_wbin = '0; m_full = 1'b0; m_af = 1'b0; m_lvl = '0; m_ovf = 1'b0;
        end else begin
            acc    = w & ~m_full;
            m_ovf  = (w & m_full) | (m_ovf & ~c);
            m_wbin = m_wbin + {4'd0, acc};
            m_lvl  = m_wbin - rb5;
            m_full = (m_lvl == 5'd16);
            m_af   = (m_lvl >= 5'd12);
        end
        m_prev_rst = r;
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    logic [4:0] prev_gray = '0;

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("mem_we",      {7'd0, mem_we},      {7'd0, e.mem_we});
            cmp("wr_addr",     {4'd0, wr_addr},     {4'd0, e.wr_addr});
            cmp("wr_ptr_gray", {3'd0, wr_ptr_gray}, {3'd0, e.gray});
            cmp("full",        {7'd0, full},        {7'd0, e.full});
            cmp("almost_full", {7'd0, almost_full}, {7'd0, e.af});
            cmp("wr_level",    {3'd0, wr_level},    {3'd0, e.lvl});
            cmp("overflow",    {7'd0, overflow},    {7'd0, e.ovf});
            if (!e.after_rst && (wr_ptr_gray !== prev_gray)) begin
                cmp("gray_one_bit_step", 8'($countones(wr_ptr_gray ^ prev_gray)), 8'd1);
            end
            prev_gray = wr_ptr_gray;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wcount;
        int rb;
        rst          = 1'b1;
        wr_en        = 1'b1;
        ovf_clr      = 1'b0;
        rq_rptr_gray = '0;
        m_wbin = '0; m_full = 1'b0; m_af = 1'b0; m_lvl = '0; m_ovf = 1'b0;
        m_prev_rst = 1'b1;

        // Reset held over three edges with wr_en high, then release.
        drive(1'b1, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 0);

        // Fill: 16 accepted writes, the 17th is dropped and flags overflow.
        repeat (17) drive(1'b0, 1'b1, 1'b0, 0);

        // Overflow clear alone, then clear colliding with a new overflowing write.
        drive(1'b0, 1'b0, 1'b1, 0);
        drive(1'b0, 1'b1, 1'b1, 0);
        drive(1'b0, 1'b0, 1'b0, 0);

        // Drain visibility: read pointer moves to 4, then 5.
        drive(1'b0, 1'b0, 1'b0, 4);
        drive(1'b0, 1'b0, 1'b0, 5);
        drive(1'b0, 1'b0, 1'b0, 5);

        // Wrap: 40 writes with the read pointer trailing two entries.
        drive(1'b1, 1'b0, 1'b0, 0);
        wcount = 0;
        for (int i = 0; i < 40; i++) begin
            rb = (wcount >= 2) ? wcount - 2 : 0;
            drive(1'b0, 1'b1, 1'b0, rb);
            wcount++;
        end
        drive(1'b0, 1'b0, 1'b0, wcount - 2);

        // Reset mid-burst after 7 writes, then restart from address 0.
        drive(1'b1, 1'b0, 1'b0, 0);
        repeat (7) drive(1'b0, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side pointer and flag controller for the asynchronous FIFO, running entirely in the write clock domain (clk).
- Gates write requests into the dual-port RAM.
- Maintains the binary and Gray write pointers.
- Derives full, almost_full, fill level and a sticky overflow flag, using the read pointer after the two-flop synchronizer.
- Exports its Gray pointer for synchronization into the read domain.

Parameters:
ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits; legal range >= 2
ALMOST_FULL_THR, 12, almost_full asserts when the fill level is >= this value; legal range 1..2**ADDR_WIDTH

Ports:
clk  input  1  write-domain clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
wr_en  input  1  write request for the current cycle
rq_rptr_gray  input  ADDR_WIDTH+1  read pointer (Gray), already synchronized into clk
ovf_clr  input  1  clears the sticky overflow flag
mem_we  output  1  RAM write strobe (combinational)
wr_addr  output  ADDR_WIDTH  RAM write address (combinational, from the binary pointer)
wr_ptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer
full  output  1  registered full flag
almost_full  output  1  registered, level >= ALMOST_FULL_THR
wr_level  output  ADDR_WIDTH+1  registered fill level, 0..2**ADDR_WIDTH
overflow  output  1  sticky: a write was attempted while full

Behaviour:
- Reset (rst=1 at a clock edge):
  - wbin, wr_ptr_gray, wr_level, full, almost_full and overflow all go to 0.
  - Reset overrides any same-cycle wr_en or ovf_clr.
  - The controller is operational from the first edge after rst drops.
  - Reset mid-burst discards the pointer; re-aligning the read side is handled at system level.
- Accept: accept = wr_en & ~full, with full as the registered value.
  - mem_we = accept, same cycle.
  - wr_addr = wbin[ADDR_WIDTH-1:0].
  - The RAM captures data on the same edge on which the pointer advances.
- Next-pointer values:
  - wbin_next = wbin + accept, modulo 2**(ADDR_WIDTH+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - Both are registered every cycle, so wr_ptr_gray updates 1 cycle after the accepted write.
- full_next = (wgray_next == {~rq_rptr_gray[ADDR_WIDTH:ADDR_WIDTH-1], rq_rptr_gray[ADDR_WIDTH-2:0]}).
  - This is recomputed every cycle, with or without a write.
  - full therefore rises on the edge that accepts the final write, and falls 1 cycle after rq_rptr_gray advances.
- Fill level:
  - rbin = Gray-to-binary of rq_rptr_gray (combinational XOR prefix from the MSB).
  - wr_level_next = wbin_next - rbin, modulo 2**(ADDR_WIDTH+1).
  - almost_full_next = (wr_level_next >= ALMOST_FULL_THR).
  - Because the read pointer lags, the level is pessimistic: it never reports less than the true occupancy.
- Overflow:
  - Set on the edge after a cycle with wr_en & full.
  - Cleared by ovf_clr.
  - If set and clear occur in the same cycle, set wins.
  - Overflowing writes are dropped: no mem_we, pointer unchanged.
- Wrap-around: the pointer wraps from 2**(ADDR_WIDTH+1)-1 to 0 with no special handling. The Gray code changes exactly one bit per increment, including at the wrap.
- Simultaneous write and read-pointer advance while full: full stays 1 this cycle, so the write is rejected. full_next is evaluated against the new rq_rptr_gray.
- No combinational path from rq_rptr_gray to any output other than through registers; mem_we and wr_addr depend only on wr_en and state.

Test Plan:
All scenarios use ADDR_WIDTH=4 and ALMOST_FULL_THR=12.
1. Reset: hold rst 3 cycles with wr_en=1 -> all outputs 0, mem_we=0 during reset cycles' edges have no effect; after release, wr_addr=0.
2. Fill: rq_rptr_gray=0, wr_en=1 for 17 cycles ->
   - mem_we=1 on the first 16 cycles; wr_addr runs 0..15.
   - almost_full rises after write 12 (wr_level=12).
   - full rises after write 16 with wr_ptr_gray=5'b11000 and wr_level=16.
   - Cycle 17: mem_we=0, overflow=1 next cycle.
3. Overflow clear: while full, pulse ovf_clr alone -> overflow=0. Then wr_en=1 with ovf_clr=1 in the same cycle -> overflow=1.
4. Drain visibility: from full, rq_rptr_gray=5'b00110 (4) -> next cycle full=0, wr_level=12, almost_full=1. Then rq_rptr_gray=5'b00111 (5) -> wr_level=11, almost_full=0.
5. Wrap: 40 writes with rq_rptr_gray tracking 2 entries behind ->
   - full never asserts; wr_level stays <= 3.
   - wr_ptr_gray goes 5'b10000 (31) -> 5'b00000 (0).
   - Each Gray transition flips exactly one bit (checker).
6. Reset mid-burst: after 7 writes, assert rst 1 cycle with wr_en=1 -> wr_ptr_gray=0, wr_level=0, no mem_we at the reset edge. The next write after release goes to wr_addr=0.
